ball_engine: RTL and testbench
==============================

# ball_engine

Parametrised ball motion engine for the brick-breaker playfield. Holds the ball at a serve position until launched, then moves it once per frame tick and reflects it off the walls, the paddle and any of N blocks. Collision pulses are latched between ticks so none is lost. Sits between the collision comparators and the VGA colour mux, and drives ball position and size to the paddle and block collision logic.

## Interface
- SCREEN_W, 640: playfield width in pixels.
- SCREEN_H, 480: playfield height in pixels.
- BALL_SIZE, 20: ball edge length in pixels; the ball is square.
- TICK_DIV, 416667: clk cycles per movement tick (60 Hz at 25 MHz).
- N_BLOCKS, 10: number of block collision inputs.
- START_X, 0 / START_Y, 250: serve position, top-left corner.
- SPD_W, 2: width of the speed input.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-low.
- x, y  in  10 each  current scan pixel.
- active_pixels  in  1  high inside the visible area.
- launch  in  1  level; starts play from SERVE.
- speed  in  SPD_W  pixels per tick on each axis; sampled at launch.
- collide_paddle  in  1  paddle overlap.
- collide_block  in  N_BLOCKS  per-block overlap.
- vga_color  out  24  white (24'hFFFFFF) inside the ball and active_pixels; 0 otherwise. Combinational.
- ball_x, ball_y  out  10 each  registered top-left position.
- ball_size  out  10  constant BALL_SIZE.
- state  out  2  0=SERVE, 1=PLAY, 2=MISS.
- miss  out  1  one-cycle pulse on entering MISS.
- tick  out  1  one-cycle movement strobe.

## Operation
- The tick counter counts 0..TICK_DIV-1. `tick` is high in the cycle where the count equals TICK_DIV-1, then the counter wraps to 0. The counter runs in all states.
- SERVE:
  - Position is forced to (START_X, START_Y), direction to +x/+y.
  - When `launch` is high on a tick, latch vel = (speed==0 ? 1 : speed) and go to PLAY.
- PLAY, on each tick:
  - Compute next position at 11-bit width: pos ± vel.
  - X axis: if the next x is ≤0, clamp to 0 and set dir +x. If next x + BALL_SIZE ≥ SCREEN_W, clamp to SCREEN_W-BALL_SIZE and set dir -x.
  - Y axis top: same clamp rule at 0, setting dir +y.
  - Y axis bottom: at SCREEN_H-BALL_SIZE, behaviour depends on the Configuration macro.
  - Collisions, applied after wall logic; highest priority first:
    - Latched paddle collision: dir -y (up), and y is not clamped.
    - Any latched block collision (OR-reduce): dir +y.
    - Paddle and block latched in the same tick: paddle wins.
- Collision latch: each input is ORed into a sticky flag every cycle. The flag is cleared on the cycle following a tick, so a pulse arriving during a tick cycle survives to the next tick. Flags are ignored outside PLAY.
- MISS: stays one tick, then returns to SERVE. `miss` pulses on the cycle the state becomes MISS.
- `launch` held continuously re-launches immediately after each serve.

## Timing
- Reset values:
  - ball_x=START_X, ball_y=START_Y, dir +x/+y, vel=1.
  - state=SERVE, miss=0, tick=0, counter=0, collision flags=0.
  - vga_color follows x/y combinationally.
- Position, state and direction all update in the cycle after `tick` is high. ball_x/ball_y carry the new value in that same cycle, with no extra lag stage.
- Latency from collision input to direction change is at most one tick period.
- Reset asserted mid-move returns to SERVE immediately (asynchronous).
- The clamp rule guarantees that 0 ≤ ball_x ≤ SCREEN_W-BALL_SIZE and 0 ≤ ball_y ≤ SCREEN_H-BALL_SIZE for any speed.

## Configuration
- BALL_BOTTOM_MISS_EN defined: reaching y ≥ SCREEN_H-BALL_SIZE clamps y and enters MISS. A paddle collision latched in that same tick takes precedence: dir -y, no miss.
- Not defined: the bottom wall reflects like the other walls (dir -y). MISS is unreachable and `miss` stays 0.

## Structure
- Package `ball_pkg`:
  - State encodings BALL_SERVE/BALL_PLAY/BALL_MISS.
  - Colour constants COLOR_BALL=24'hFFFFFF and COLOR_BG=24'h000000.
  - 11-bit coordinate typedef.
- Sub-module `tick_gen` (parameter DIV; ports clk, rst, tick) holds the divider. It is reusable by the paddle block.

## Test plan
Bench runs with TICK_DIV=4, BALL_SIZE=20, defaults otherwise.
- Reset, no launch, 10 ticks -> ball stays at (0,250), state=0.
- Launch with speed=2 -> after 1 tick (2,252), after 3 ticks (6,256).
- Speed=3, ball at x=618 moving +x -> next tick x=620 (clamped), dir -x; following tick x=617.
- One-cycle collide_block[7] pulse mid-period, ball moving -y -> next tick y increases by vel.
- collide_paddle and collide_block[0] in the same tick -> dir -y.
- With BALL_BOTTOM_MISS_EN, y reaches 460 with no paddle -> miss pulses once, state 2 for one tick, then SERVE at (0,250). Without the macro -> dir -y, miss stays 0.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared types and constants for the brick-breaker ball engine.
package ball_pkg;

  typedef enum logic [1:0] {
    BALL_SERVE = 2'd0,
    BALL_PLAY  = 2'd1,
    BALL_MISS  = 2'd2
  } ball_state_t;

  localparam logic [23:0] COLOR_BALL = 24'hFFFFFF;
  localparam logic [23:0] COLOR_BG   = 24'h000000;

  // Signed so that a step past the left/top edge is seen as <= 0.
  typedef logic signed [10:0] coord_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle strobe every DIV clocks.
// Shared with the paddle block.
module tick_gen #(
  parameter int DIV = 416667
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(DIV - 1));
  assign tick   = w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Ball motion engine: serve/play/miss FSM, wall and collision reflection.
// Define BALL_BOTTOM_MISS_EN to make the bottom wall a miss instead of a bounce.
module ball_engine
  import ball_pkg::*;
#(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 20,
  parameter int TICK_DIV  = 416667,
  parameter int N_BLOCKS  = 10,
  parameter int START_X   = 0,
  parameter int START_Y   = 250,
  parameter int SPD_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                active_pixels,
  input  logic                launch,
  input  logic [SPD_W-1:0]    speed,
  input  logic                collide_paddle,
  input  logic [N_BLOCKS-1:0] collide_block,
  output logic [23:0]         vga_color,
  output logic [9:0]          ball_x,
  output logic [9:0]          ball_y,
  output logic [9:0]          ball_size,
  output logic [1:0]          state,
  output logic                miss,
  output logic                tick
);

  localparam coord_t X_MAX = coord_t'(SCREEN_W - BALL_SIZE);
  localparam coord_t Y_MAX = coord_t'(SCREEN_H - BALL_SIZE);

  ball_state_t      r_state;
  logic [9:0]       r_x, r_y;
  logic             r_dx, r_dy;  // 1 = increasing coordinate
  logic [SPD_W-1:0] r_vel;
  logic             r_pad, r_blk, r_miss;

  logic   w_tick, w_eff_dy, w_in_x, w_in_y;
  coord_t w_vel, w_nx, w_ny;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Sticky collision flags; a tick edge reloads them with the live input so
  // a pulse coinciding with the tick is carried into the next period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pad <= 1'b0;
      r_blk <= 1'b0;
    end else if (w_tick) begin
      r_pad <= collide_paddle;
      r_blk <= |collide_block;
    end else begin
      r_pad <= r_pad | collide_paddle;
      r_blk <= r_blk | (|collide_block);
    end
  end

  assign w_vel = coord_t'(r_vel);

  always_comb begin
    w_eff_dy = r_dy;
    if (r_pad) begin
      w_eff_dy = 1'b0;
    end else if (r_blk) begin
      w_eff_dy = 1'b1;
    end
    w_nx = r_dx     ? coord_t'(r_x) + w_vel : coord_t'(r_x) - w_vel;
    w_ny = w_eff_dy ? coord_t'(r_y) + w_vel : coord_t'(r_y) - w_vel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= BALL_SERVE;
      r_x     <= 10'(START_X);
      r_y     <= 10'(START_Y);
      r_dx    <= 1'b1;
      r_dy    <= 1'b1;
      r_vel   <= SPD_W'(1);
      r_miss  <= 1'b0;
    end else begin
      r_miss <= 1'b0;
      case (r_state)
        BALL_SERVE: begin
          r_x  <= 10'(START_X);
          r_y  <= 10'(START_Y);
          r_dx <= 1'b1;
          r_dy <= 1'b1;
          if (w_tick && launch) begin
            r_vel   <= (speed == '0) ? SPD_W'(1) : speed;
            r_state <= BALL_PLAY;
          end
        end
        BALL_PLAY: begin
          if (w_tick) begin
            if (w_nx <= coord_t'(0)) begin
              r_x  <= 10'd0;
              r_dx <= 1'b1;
            end else if (w_nx >= X_MAX) begin
              r_x  <= 10'(X_MAX);
              r_dx <= 1'b0;
            end else begin
              r_x <= w_nx[9:0];
            end

            if (w_ny <= coord_t'(0)) begin
              r_y  <= 10'd0;
              r_dy <= 1'b1;
            end else if (w_ny >= Y_MAX) begin
              r_y <= 10'(Y_MAX);
`ifdef BALL_BOTTOM_MISS_EN
              if (r_pad) begin
                r_dy <= 1'b0;
              end else begin
                r_dy    <= w_eff_dy;
                r_state <= BALL_MISS;
                r_miss  <= 1'b1;
              end
`else
              r_dy <= 1'b0;
`endif
            end else begin
              r_y  <= w_ny[9:0];
              r_dy <= w_eff_dy;
            end
          end
        end
        BALL_MISS: begin
          if (w_tick) begin
            r_state <= BALL_SERVE;
            r_x     <= 10'(START_X);
            r_y     <= 10'(START_Y);
            r_dx    <= 1'b1;
            r_dy    <= 1'b1;
          end
        end
        default: r_state <= BALL_SERVE;
      endcase
    end
  end

  assign w_in_x = ({1'b0, x} >= {1'b0, r_x}) && ({1'b0, x} < ({1'b0, r_x} + 11'(BALL_SIZE)));
  assign w_in_y = ({1'b0, y} >= {1'b0, r_y}) && ({1'b0, y} < ({1'b0, r_y} + 11'(BALL_SIZE)));

  assign vga_color = (active_pixels && w_in_x && w_in_y) ? COLOR_BALL : COLOR_BG;
  assign ball_x    = r_x;
  assign ball_y    = r_y;
  assign ball_size = 10'(BALL_SIZE);
  assign state     = r_state;
  assign miss      = r_miss;
  assign tick      = w_tick;

endmodule

// File: tb/tb_ball_engine.sv
// Directed scoreboard bench for ball_engine (TICK_DIV=4, BALL_SIZE=20).
module tb_ball_engine;
  import ball_pkg::*;

  localparam int TDIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic        active_pixels = 1'b0;
  logic        launch = 1'b0;
  logic [1:0]  speed = '0;
  logic        collide_paddle = 1'b0;
  logic [9:0]  collide_block = '0;
  logic [23:0] vga_color;
  logic [9:0]  ball_x, ball_y, ball_size;
  logic [1:0]  state;
  logic        miss, tick;

  ball_engine #(.TICK_DIV(TDIV), .BALL_SIZE(20)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .active_pixels(active_pixels),
    .launch(launch), .speed(speed), .collide_paddle(collide_paddle),
    .collide_block(collide_block), .vga_color(vga_color), .ball_x(ball_x),
    .ball_y(ball_y), .ball_size(ball_size), .state(state), .miss(miss), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] st;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0, n_fail = 0, miss_cnt = 0, exp_miss = 0;
  int   mx, my, mdx, mdy, mv, mst;
  bit   pend_pad, pend_blk;

  always @(negedge clk) if (miss === 1'b1) miss_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 250; mdx = 1; mdy = 1; mv = 1; mst = 0;
    pend_pad = 0; pend_blk = 0;
  endtask

  // Reference motion for one tick, evaluated with the bench's own inputs.
  task automatic model_tick();
    int nx, ny, edy;
    case (mst)
      0: if (launch) begin
        mv  = (speed == 0) ? 1 : int'(speed);
        mst = 1;
      end
      1: begin
        edy = pend_pad ? -1 : (pend_blk ? 1 : mdy);
        nx  = mx + mdx * mv;
        ny  = my + edy * mv;
        if (nx <= 0) begin mx = 0; mdx = 1; end
        else if (nx + 20 >= 640) begin mx = 620; mdx = -1; end
        else mx = nx;
        if (ny <= 0) begin my = 0; mdy = 1; end
        else if (ny + 20 >= 480) begin
          my = 460;
`ifdef BALL_BOTTOM_MISS_EN
          if (pend_pad) mdy = -1;
          else begin mdy = edy; mst = 2; exp_miss++; end
`else
          mdy = -1;
`endif
        end else begin my = ny; mdy = edy; end
      end
      default: begin mst = 0; mx = 0; my = 250; mdx = 1; mdy = 1; end
    endcase
    pend_pad = 0;
    pend_blk = 0;
  endtask

  // One movement tick; optional collision pulses driven in the tick cycle itself.
  task automatic tick_step(input bit pad_on_tick, input bit blk_on_tick);
    exp_t e;
    int   k;
    model_tick();
    e.x = 10'(mx); e.y = 10'(my); e.st = 2'(mst);
    sb_q.push_back(e);
    k = 0;
    while (tick !== 1'b1 && k < 3 * TDIV) begin
      @(negedge clk);
      k++;
    end
    check("tick_seen", 32'(tick), 32'd1);
    if (pad_on_tick) collide_paddle = 1'b1;
    if (blk_on_tick) collide_block[7] = 1'b1;
    @(posedge clk); #1;
    collide_paddle = 1'b0;
    collide_block  = '0;
    if (pad_on_tick) pend_pad = 1;
    if (blk_on_tick) pend_blk = 1;
    e = sb_q.pop_front();
    check("ball_x", 32'(ball_x), 32'(e.x));
    check("ball_y", 32'(ball_y), 32'(e.y));
    check("state",  32'(state),  32'(e.st));
  endtask

  // One-cycle collision pulse away from the tick cycle.
  task automatic pulse_mid(input bit pad, input int blk_idx);
    @(posedge clk); #1;
    if (pad) collide_paddle = 1'b1;
    if (blk_idx >= 0) collide_block[blk_idx] = 1'b1;
    @(posedge clk); #1;
    collide_paddle = 1'b0;
    collide_block  = '0;
    if (pad) pend_pad = 1;
    if (blk_idx >= 0) pend_blk = 1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    model_reset();
    miss_cnt = 0;
    exp_miss = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(ball_x), 32'd0);
    check("rst_y", 32'(ball_y), 32'd250);
    check("rst_state", 32'(state), 32'd0);
    check("rst_miss", 32'(miss), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("ball_size", 32'(ball_size), 32'd20);
    active_pixels = 1'b1; x = 10'd5; y = 10'd260; #1;
    check("vga_in", 32'(vga_color), 32'hFFFFFF);
    x = 10'd19; y = 10'd269; #1;
    check("vga_corner", 32'(vga_color), 32'hFFFFFF);
    x = 10'd20; #1;
    check("vga_right_out", 32'(vga_color), 32'h0);
    x = 10'd5; y = 10'd270; #1;
    check("vga_below_out", 32'(vga_color), 32'h0);
    y = 10'd260; active_pixels = 1'b0; #1;
    check("vga_blank", 32'(vga_color), 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    repeat (10) tick_step(0, 0);

    speed = 2'd2; launch = 1'b1;
    tick_step(0, 0);
    launch = 1'b0;
    tick_step(0, 0);
    check("spd2_t1", {ball_x, ball_y}, {10'd2, 10'd252});
    tick_step(0, 0);
    tick_step(0, 0);
    check("spd2_t3", {ball_x, ball_y}, {10'd6, 10'd256});

    @(posedge clk); #2;
    rst = 1'b0; #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_pos", {ball_x, ball_y}, {10'd0, 10'd250});
    @(negedge clk); rst = 1'b1;
    model_reset();
    @(posedge clk); #1;

    speed = 2'd3; launch = 1'b1;
    tick_step(0, 0);
    launch = 1'b0;
    repeat (69) tick_step(0, 0);
    pulse_mid(1'b1, 0);
    tick_step(0, 0);
    check("pad_beats_blk_y", 32'(ball_y), 32'd454);
    repeat (136) tick_step(0, 0);
    check("pre_wall_x", 32'(ball_x), 32'd618);
    tick_step(0, 0);
    check("wall_clamp_x", 32'(ball_x), 32'd620);
    tick_step(0, 0);
    check("wall_reflect_x", 32'(ball_x), 32'd617);
    check("moving_up_y", 32'(ball_y), 32'd40);
    pulse_mid(1'b0, 7);
    tick_step(0, 0);
    check("blk7_down_y", 32'(ball_y), 32'd43);
    tick_step(1, 0);
    check("pad_in_tick_y", 32'(ball_y), 32'd46);
    tick_step(0, 0);
    check("pad_carried_y", 32'(ball_y), 32'd43);

    do_reset();
    speed = 2'd3; launch = 1'b1;
    tick_step(0, 0);
    launch = 1'b0;
    repeat (70) tick_step(0, 0);
    check("bottom_y", 32'(ball_y), 32'd460);
`ifdef BALL_BOTTOM_MISS_EN
    check("miss_state", 32'(state), 32'd2);
    tick_step(0, 0);
    check("miss_to_serve", {ball_x, ball_y, state}, {10'd0, 10'd250, 2'd0});
    check("miss_pulses", 32'(miss_cnt), 32'd1);
`else
    tick_step(0, 0);
    check("bottom_reflect_y", 32'(ball_y), 32'd457);
    check("no_miss_pulses", 32'(miss_cnt), 32'd0);
`endif
    check("miss_count_model", 32'(miss_cnt), 32'(exp_miss));

    do_reset();
    speed = 2'd0; launch = 1'b1;
    tick_step(0, 0);
    launch = 1'b0;
    tick_step(0, 0);
    check("spd0_as_1", {ball_x, ball_y}, {10'd1, 10'd251});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
